mmio_bus_ctrl: RTL and testbench
================================

# mmio_bus_ctrl

Sequencer for the MEM stage's external data-bus path. It detects loads and stores whose address falls in the MMIO window and issues a single bus transaction for each one. While the transaction is outstanding it stalls the pipeline. It then returns the completion strobes (`d_valid`/`d_ready`) and `d_rdata` that the MEM stage uses to select bus data and to suppress local data-memory writes. It sits between EX/MEM pipeline registers and the peripheral bus, beside the local data memory.

## Interface
- `ADDR_TAG_W`, 16: number of top address bits compared against the MMIO tag.
- `MMIO_TAG`, 16'hFFFF: a request is MMIO when `req_addr[63 -: ADDR_TAG_W] == MMIO_TAG`.
- `TIMEOUT`, 255: maximum number of cycles spent in REQ+WAIT before a bus error; legal range 2..2^TIMEOUT_W-1.
- `TIMEOUT_W`, 8: width of the timeout counter.

Ports:
- `clock` in 1: clock.
- `reset` in 1: asynchronous, active-high.
- `req_load_type` in 2: 0 = none, 1 = byte, 2 = word, 3 = dword.
- `req_store_type` in 2: same encoding as `req_load_type`.
- `req_addr` in 64: effective address.
- `req_wdata` in 64: store data.
- `flush` in 1: exception flush of the instruction currently in MEM.
- `mmio_hit` out 1: combinational address-window match, qualified by a load or store being requested.
- `stall` out 1: freeze the pipeline upstream of MEM.
- `d_valid` out 1: one-cycle load completion strobe.
- `d_ready` out 1: one-cycle store completion strobe.
- `d_rdata` out 64: load data, valid while `d_valid` is high.
- `bus_error` out 1: one-cycle pulse to cp0 on timeout.
- `bus_req` out 1, `bus_we` out 1, `bus_addr` out 64, `bus_wdata` out 64, `bus_size` out 2: master request channel.
- `bus_ready` in 1: slave accepts the request.
- `bus_valid` in 1: slave completes the transaction.
- `bus_rdata` in 64: slave read data.

## Operation
- States: IDLE, REQ, WAIT, DONE, ERR.
- `access` = `|req_load_type | |req_store_type`.
- If `req_load_type` and `req_store_type` are both nonzero, the request is treated as a load; the store is ignored.
- IDLE → REQ when `access & mmio_hit & ~flush`.
  - Latch `bus_addr`, `bus_wdata`, `bus_we` (= no load), and `bus_size` (= load type if loading, else store type).
  - Clear the timeout counter.
- REQ: `bus_req` = 1.
  - `bus_ready & bus_valid` → DONE, capture `bus_rdata`.
  - `bus_ready` alone → WAIT.
  - `flush` while `bus_ready` is low → IDLE with no completion. Once a request has been accepted, `flush` is ignored.
- WAIT: `bus_req` = 0; `bus_valid` → DONE, capture `bus_rdata`.
- Timeout: the counter increments on every REQ/WAIT cycle.
  - When the counter reaches `TIMEOUT-1` without completion → ERR.
  - Completion in the same cycle takes priority over timeout.
- DONE: `d_valid` = `~bus_we`, `d_ready` = `bus_we`, `stall` = 0 → IDLE.
- ERR: `bus_error` = 1; `d_valid` = `~bus_we` with `d_rdata` = all ones; `d_ready` = `bus_we` → IDLE.
- `stall` = `(IDLE & access & mmio_hit & ~flush) | REQ | WAIT`.
- `d_rdata` is the captured register; it holds its value outside DONE/ERR.

## Timing
- Reset values: state IDLE; `bus_req`, `bus_we`, `bus_size`, `bus_addr`, `bus_wdata`, `d_rdata`, and the counter all 0. All derived outputs are therefore 0 in reset.
- Reset asserted mid-transaction aborts to IDLE. No DONE/ERR pulse follows; the slave must tolerate the abandoned request.
- Minimum latency, detect to strobe:
  - Cycle 0: IDLE detect, `stall`.
  - Cycle 1: REQ with `bus_ready & bus_valid`.
  - Cycle 2: DONE strobe, `stall` low.
  - Total: two stall cycles.
- Completion strobes last exactly one cycle. The pipeline advances on the strobe cycle, so the next instruction is evaluated in IDLE on the following cycle with no re-issue.
- `bus_*` request outputs are registered. `mmio_hit`, `stall`, and the strobes are combinational from state and inputs.
- Back-to-back MMIO accesses: IDLE → REQ costs one detect cycle. There is no bypass from DONE straight to REQ.

## Structure
- Add `mmio_state_t` (the 3-bit enum) and the `MEM_NONE`/`MEM_BYTE`/`MEM_WORD`/`MEM_DWORD` constants to the `structures` package.
- Single module with no sub-modules; the timeout counter stays inline.

## Test plan
- Load from 0x0000_0000_0000_1000 → `mmio_hit` = 0, `stall` = 0, `bus_req` never asserted.
- Word load from 0xFFFF_0000_0000_0010; slave asserts ready in cycle 1 and valid in cycle 3 with 0x1234 → `bus_size` = 2, `stall` high for cycles 0–3, `d_valid` pulse in cycle 4 with `d_rdata` = 0x1234.
- Dword store of 0xDEADBEEF_CAFEF00D to 0xFFFF_0000_0000_0008; ready and valid both in cycle 1 → `bus_we` = 1, `bus_wdata` matches, `d_ready` pulse in cycle 2, `d_valid` = 0.
- `TIMEOUT` = 8 with the slave never asserting valid → ERR entered after 8 REQ/WAIT cycles; `bus_error` and `d_valid` pulse with `d_rdata` = 0xFFFF_FFFF_FFFF_FFFF; `stall` drops.
- Completion on the same cycle the counter reaches `TIMEOUT-1` → DONE, no `bus_error`.
- Reset during WAIT → all outputs 0 immediately; a late `bus_valid` afterwards produces no strobe. `flush` in REQ before ready → IDLE with no strobe.

Source files
------------

// File: rtl/structures.sv
// ============================================================================
// Package  : structures
// Purpose  : Shared MEM-stage types and access-size codes.
// Revision : 1.0 - initial MMIO sequencer types
// ============================================================================
`default_nettype none

package structures;

  typedef enum logic [2:0] {
    MMIO_IDLE = 3'd0,
    MMIO_REQ  = 3'd1,
    MMIO_WAIT = 3'd2,
    MMIO_DONE = 3'd3,
    MMIO_ERR  = 3'd4
  } mmio_state_t;

  localparam logic [1:0] MEM_NONE  = 2'd0;
  localparam logic [1:0] MEM_BYTE  = 2'd1;
  localparam logic [1:0] MEM_WORD  = 2'd2;
  localparam logic [1:0] MEM_DWORD = 2'd3;

  // A load wins when both a load and a store are presented.
  function automatic logic [1:0] mem_size_sel(input logic [1:0] load_type,
                                              input logic [1:0] store_type);
    return (load_type != MEM_NONE) ? load_type : store_type;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mmio_bus_ctrl.sv
// ============================================================================
// Module   : mmio_bus_ctrl
// Purpose  : Issues one external bus transaction per MMIO load/store in MEM,
//            stalling the pipeline until completion or timeout.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mmio_bus_ctrl
  import structures::*;
#(
  parameter int                    ADDR_TAG_W = 16,
  parameter logic [ADDR_TAG_W-1:0] MMIO_TAG   = 16'hFFFF,
  parameter int                    TIMEOUT    = 255,
  parameter int                    TIMEOUT_W  = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [1:0]  req_load_type,
  input  logic [1:0]  req_store_type,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  input  logic        flush,
  output logic        mmio_hit,
  output logic        stall,
  output logic        d_valid,
  output logic        d_ready,
  output logic [63:0] d_rdata,
  output logic        bus_error,
  output logic        bus_req,
  output logic        bus_we,
  output logic [63:0] bus_addr,
  output logic [63:0] bus_wdata,
  output logic [1:0]  bus_size,
  input  logic        bus_ready,
  input  logic        bus_valid,
  input  logic [63:0] bus_rdata
);

  localparam logic [TIMEOUT_W-1:0] c_timeout_last = TIMEOUT_W'(TIMEOUT - 1);

  mmio_state_t          r_state;
  logic [TIMEOUT_W-1:0] r_count;
  logic                 r_bus_req;
  logic                 r_bus_we;
  logic [1:0]           r_bus_size;
  logic [63:0]          r_bus_addr;
  logic [63:0]          r_bus_wdata;
  logic [63:0]          r_d_rdata;

  logic w_access;
  logic w_is_load;
  logic w_tag_match;
  logic w_issue;
  logic w_expired;
  logic w_strobe;

  assign w_access    = (|req_load_type) | (|req_store_type);
  assign w_is_load   = |req_load_type;
  assign w_tag_match = (req_addr[63 -: ADDR_TAG_W] == MMIO_TAG);
  assign mmio_hit    = w_access & w_tag_match;
  assign w_issue     = (r_state == MMIO_IDLE) & mmio_hit & ~flush;
  assign w_expired   = (r_count == c_timeout_last);

  // Priority inside REQ/WAIT: completion, then flush (REQ only), then timeout.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= MMIO_IDLE;
      r_count     <= '0;
      r_bus_req   <= 1'b0;
      r_bus_we    <= 1'b0;
      r_bus_size  <= MEM_NONE;
      r_bus_addr  <= '0;
      r_bus_wdata <= '0;
      r_d_rdata   <= '0;
    end else begin
      case (r_state)
        MMIO_IDLE: begin
          if (w_issue) begin
            r_state     <= MMIO_REQ;
            r_bus_req   <= 1'b1;
            r_bus_we    <= ~w_is_load;
            r_bus_size  <= mem_size_sel(req_load_type, req_store_type);
            r_bus_addr  <= req_addr;
            r_bus_wdata <= req_wdata;
            r_count     <= '0;
          end
        end

        MMIO_REQ: begin
          if (bus_ready & bus_valid) begin
            r_state   <= MMIO_DONE;
            r_bus_req <= 1'b0;
            r_d_rdata <= bus_rdata;
          end else if (~bus_ready & flush) begin
            r_state   <= MMIO_IDLE;
            r_bus_req <= 1'b0;
          end else if (w_expired) begin
            r_state   <= MMIO_ERR;
            r_bus_req <= 1'b0;
            r_d_rdata <= '1;
          end else if (bus_ready) begin
            r_state   <= MMIO_WAIT;
            r_bus_req <= 1'b0;
            r_count   <= r_count + 1'b1;
          end else begin
            r_count   <= r_count + 1'b1;
          end
        end

        MMIO_WAIT: begin
          if (bus_valid) begin
            r_state   <= MMIO_DONE;
            r_d_rdata <= bus_rdata;
          end else if (w_expired) begin
            r_state   <= MMIO_ERR;
            r_d_rdata <= '1;
          end else begin
            r_count   <= r_count + 1'b1;
          end
        end

        MMIO_DONE: r_state <= MMIO_IDLE;
        MMIO_ERR:  r_state <= MMIO_IDLE;
        default:   r_state <= MMIO_IDLE;
      endcase
    end
  end

  assign w_strobe  = (r_state == MMIO_DONE) | (r_state == MMIO_ERR);
  assign stall     = w_issue | (r_state == MMIO_REQ) | (r_state == MMIO_WAIT);
  assign d_valid   = w_strobe & ~r_bus_we;
  assign d_ready   = w_strobe & r_bus_we;
  assign bus_error = (r_state == MMIO_ERR);
  assign d_rdata   = r_d_rdata;
  assign bus_req   = r_bus_req;
  assign bus_we    = r_bus_we;
  assign bus_size  = r_bus_size;
  assign bus_addr  = r_bus_addr;
  assign bus_wdata = r_bus_wdata;

endmodule

`default_nettype wire

// File: tb/tb_mmio_bus_ctrl.sv
// ============================================================================
// Module   : tb_mmio_bus_ctrl
// Purpose  : Self-checking bench for mmio_bus_ctrl against a transaction model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mmio_bus_ctrl;
  import structures::*;

  localparam int TO = 8;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  req_load_type, req_store_type;
  logic [63:0] req_addr, req_wdata;
  logic        flush;
  logic        mmio_hit, stall, d_valid, d_ready, bus_error;
  logic [63:0] d_rdata;
  logic        bus_req, bus_we;
  logic [63:0] bus_addr, bus_wdata;
  logic [1:0]  bus_size;
  logic        bus_ready, bus_valid;
  logic [63:0] bus_rdata;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clock = ~clock;

  mmio_bus_ctrl #(
    .ADDR_TAG_W(16), .MMIO_TAG(16'hFFFF), .TIMEOUT(TO), .TIMEOUT_W(8)
  ) dut (
    .clock(clock), .reset(reset),
    .req_load_type(req_load_type), .req_store_type(req_store_type),
    .req_addr(req_addr), .req_wdata(req_wdata), .flush(flush),
    .mmio_hit(mmio_hit), .stall(stall), .d_valid(d_valid), .d_ready(d_ready),
    .d_rdata(d_rdata), .bus_error(bus_error),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_size(bus_size),
    .bus_ready(bus_ready), .bus_valid(bus_valid), .bus_rdata(bus_rdata)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Transaction-level model: one outstanding access, its age, and a pending strobe.
  bit          m_busy, m_accepted;
  int          m_age, m_strobe;   // strobe: 0 none, 1 completion, 2 timeout
  logic        m_we;
  logic [1:0]  m_size;
  logic [63:0] m_addr, m_wdata, m_rdata;

  task automatic model_reset();
    m_busy = 0; m_accepted = 0; m_age = 0; m_strobe = 0;
    m_we = 0; m_size = 0; m_addr = 0; m_wdata = 0; m_rdata = 0;
  endtask

  function automatic bit want_access();
    bit acc = (req_load_type != 0) || (req_store_type != 0);
    return acc && (req_addr[63:48] == 16'hFFFF);
  endfunction

  task automatic model_compare();
    bit hit   = want_access();
    bit issue = !m_busy && (m_strobe == 0) && hit && !flush;
    check("mmio_hit",  64'(mmio_hit),  64'(hit));
    check("stall",     64'(stall),     64'(issue || m_busy));
    check("bus_req",   64'(bus_req),   64'(m_busy && !m_accepted));
    check("bus_we",    64'(bus_we),    64'(m_we));
    check("bus_size",  64'(bus_size),  64'(m_size));
    check("bus_addr",  bus_addr,       m_addr);
    check("bus_wdata", bus_wdata,      m_wdata);
    check("d_valid",   64'(d_valid),   64'((m_strobe != 0) && !m_we));
    check("d_ready",   64'(d_ready),   64'((m_strobe != 0) && m_we));
    check("bus_error", 64'(bus_error), 64'(m_strobe == 2));
    check("d_rdata",   d_rdata,        m_rdata);
  endtask

  task automatic model_step();
    bit done;
    if (m_strobe != 0) begin
      m_strobe = 0;
    end else if (!m_busy) begin
      if (want_access() && !flush) begin
        m_busy = 1; m_accepted = 0; m_age = 0;
        m_we    = (req_load_type == 0);
        m_size  = (req_load_type != 0) ? req_load_type : req_store_type;
        m_addr  = req_addr;
        m_wdata = req_wdata;
      end
    end else begin
      done = m_accepted ? bus_valid : (bus_ready && bus_valid);
      if (done) begin
        m_rdata = bus_rdata; m_strobe = 1; m_busy = 0;
      end else if (!m_accepted && !bus_ready && flush) begin
        m_busy = 0;
      end else if (m_age == TO - 1) begin
        m_rdata = '1; m_strobe = 2; m_busy = 0;
      end else begin
        if (bus_ready) m_accepted = 1;
        m_age++;
      end
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(negedge clock);
      if (reset) model_reset();
      model_compare();
      if (!reset) model_step();
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    req_load_type = MEM_NONE; req_store_type = MEM_NONE;
    req_addr = '0; req_wdata = '0; flush = 0;
    bus_ready = 0; bus_valid = 0; bus_rdata = '0;
  endtask

  task automatic issue_load(input logic [1:0] t, input logic [63:0] a);
    req_load_type = t; req_store_type = MEM_NONE; req_addr = a; req_wdata = '0;
  endtask

  initial begin
    idle_inputs();
    reset = 1;
    tick();
    #2;
    check("rst_stall", 64'(stall), 64'd0);
    check("rst_bus_req", 64'(bus_req), 64'd0);
    check("rst_bus_addr", bus_addr, 64'd0);
    check("rst_d_rdata", d_rdata, 64'd0);
    tick();
    reset = 0;

    // Address outside the MMIO window
    issue_load(MEM_WORD, 64'h0000_0000_0000_1000);
    #2;
    check("nonmmio_hit", 64'(mmio_hit), 64'd0);
    check("nonmmio_stall", 64'(stall), 64'd0);
    tick(); #2;
    check("nonmmio_req", 64'(bus_req), 64'd0);
    idle_inputs(); tick();

    // Word load: ready in cycle 1, valid in cycle 3
    issue_load(MEM_WORD, 64'hFFFF_0000_0000_0010);
    #2; check("wl_c0_stall", 64'(stall), 64'd1);
    tick(); bus_ready = 1;
    #2; check("wl_c1_req", 64'(bus_req), 64'd1);
    check("wl_size", 64'(bus_size), 64'd2);
    tick(); bus_ready = 0;
    #2; check("wl_c2_req", 64'(bus_req), 64'd0);
    check("wl_c2_stall", 64'(stall), 64'd1);
    tick(); bus_valid = 1; bus_rdata = 64'h1234;
    #2; check("wl_c3_stall", 64'(stall), 64'd1);
    tick(); idle_inputs();
    #2; check("wl_c4_dvalid", 64'(d_valid), 64'd1);
    check("wl_c4_rdata", d_rdata, 64'h1234);
    check("wl_c4_stall", 64'(stall), 64'd0);
    tick(); #2; check("wl_c5_dvalid", 64'(d_valid), 64'd0);

    // Dword store, ready+valid in cycle 1
    req_store_type = MEM_DWORD; req_addr = 64'hFFFF_0000_0000_0008;
    req_wdata = 64'hDEADBEEF_CAFEF00D;
    tick(); bus_ready = 1; bus_valid = 1;
    #2; check("st_we", 64'(bus_we), 64'd1);
    check("st_wdata", bus_wdata, 64'hDEADBEEF_CAFEF00D);
    tick(); idle_inputs();
    #2; check("st_dready", 64'(d_ready), 64'd1);
    check("st_dvalid", 64'(d_valid), 64'd0);
    tick();

    // Timeout with slave silent
    issue_load(MEM_BYTE, 64'hFFFF_0000_0000_0020);
    tick();
    repeat (7) tick();
    #2; check("to_c8_stall", 64'(stall), 64'd1);
    tick(); idle_inputs();
    #2; check("to_berr", 64'(bus_error), 64'd1);
    check("to_dvalid", 64'(d_valid), 64'd1);
    check("to_rdata", d_rdata, 64'hFFFF_FFFF_FFFF_FFFF);
    check("to_stall", 64'(stall), 64'd0);
    tick(); #2; check("to_berr_off", 64'(bus_error), 64'd0);

    // Completion on the last allowed cycle
    issue_load(MEM_WORD, 64'hFFFF_0000_0000_0030);
    tick();
    repeat (7) tick();
    bus_ready = 1; bus_valid = 1; bus_rdata = 64'h55;
    tick(); idle_inputs();
    #2; check("late_berr", 64'(bus_error), 64'd0);
    check("late_dvalid", 64'(d_valid), 64'd1);
    check("late_rdata", d_rdata, 64'h55);
    tick();

    // Reset while waiting
    issue_load(MEM_DWORD, 64'hFFFF_0000_0000_0038);
    tick(); bus_ready = 1;
    tick(); bus_ready = 0;
    idle_inputs(); reset = 1;
    #2; check("rw_req", 64'(bus_req), 64'd0);
    check("rw_stall", 64'(stall), 64'd0);
    check("rw_addr", bus_addr, 64'd0);
    check("rw_rdata", d_rdata, 64'd0);
    tick(); reset = 0; bus_valid = 1; bus_rdata = 64'h77;
    #2; check("rw_dvalid", 64'(d_valid), 64'd0);
    tick(); bus_valid = 0;
    #2; check("rw_dvalid2", 64'(d_valid), 64'd0);

    // Flush before the slave accepts
    issue_load(MEM_WORD, 64'hFFFF_0000_0000_0040);
    tick(); flush = 1;
    #2; check("fl_stall", 64'(stall), 64'd1);
    tick(); idle_inputs();
    #2; check("fl_req", 64'(bus_req), 64'd0);
    check("fl_stall_off", 64'(stall), 64'd0);
    tick(); #2; check("fl_dvalid", 64'(d_valid), 64'd0);

    // Randomized traffic checked by the model
    for (int i = 0; i < 3000; i++) begin
      tick();
      if (reset) reset = 0;
      else if ($urandom_range(0, 399) == 0) reset = 1;
      req_load_type  = ($urandom_range(0, 1) == 0) ? MEM_NONE : 2'($urandom);
      req_store_type = ($urandom_range(0, 1) == 0) ? MEM_NONE : 2'($urandom);
      req_addr  = {($urandom_range(0, 2) != 0) ? 16'hFFFF : 16'($urandom), 16'($urandom), $urandom};
      req_wdata = {$urandom, $urandom};
      flush     = ($urandom_range(0, 7) == 0);
      bus_ready = ($urandom_range(0, 1) == 0);
      bus_valid = ($urandom_range(0, 4) == 0);
      bus_rdata = {$urandom, $urandom};
    end

    tick(); idle_inputs(); reset = 0;
    repeat (3) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
